spi_controller: RTL and testbench

SPI mode-0 initiator (controller) that drives spi_clk, spi_cs and spi_copi and samples spi_cipo. It is the far end of the on-chip SPI target and bus command state machine. It serves as the host-side link in integration benches and as the on-chip master for self-test and loopback of the bus. Bytes are passed in through a valid/ready handshake and returned on a one-cycle rx strobe. Consecutive bytes can be grouped under a single chip-select assertion.

---
 rtl/spi_controller.sv | 214 +++++++++++++++++++++
 tb/tb_spi_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
//==============================================================================
// Module      : spi_controller
// Description : SPI mode-0 initiator. Bytes arrive on a valid/ready handshake,
//               are shifted out MSB first on spi_copi while spi_cipo is shifted
//               in, and the received byte is returned on a one-cycle strobe.
//               Bytes without tx_last keep spi_cs asserted for the next byte.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_controller #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_byte,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       busy,
    output logic       spi_clk,
    output logic       spi_cs,
    output logic       spi_copi,
    input  logic       spi_cipo
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEAD  = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_TRAIL = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;
    localparam logic [2:0] ST_WAIT  = 3'd5;

    localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);

    logic [2:0] r_state,    w_state_nxt;
    logic [7:0] r_div,      w_div_nxt;
    logic [2:0] r_bit,      w_bit_nxt;
    logic [7:0] r_tx_sr,    w_tx_sr_nxt;
    logic [7:0] r_rx_sr,    w_rx_sr_nxt;
    logic       r_last,     w_last_nxt;
    // Set when a follow-on byte is accepted in WAIT: the first high phase is
    // preceded by one low setup cycle so spi_copi never moves with the rising edge.
    logic       r_first,    w_first_nxt;
    logic       r_tx_ready, w_tx_ready_nxt;
    logic       r_rx_valid, w_rx_valid_nxt;
    logic [7:0] r_rx_byte,  w_rx_byte_nxt;
    logic       r_busy,     w_busy_nxt;
    logic       r_spi_clk,  w_spi_clk_nxt;
    logic       r_spi_cs,   w_spi_cs_nxt;
    logic       r_copi,     w_copi_nxt;

    logic w_div_end;
    logic w_accept;

    assign w_div_end = (r_div == c_div_last);
    assign w_accept  = tx_valid & r_tx_ready;

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        w_state_nxt    = r_state;
        w_div_nxt      = r_div;
        w_bit_nxt      = r_bit;
        w_tx_sr_nxt    = r_tx_sr;
        w_rx_sr_nxt    = r_rx_sr;
        w_last_nxt     = r_last;
        w_first_nxt    = r_first;
        w_rx_valid_nxt = 1'b0;
        w_rx_byte_nxt  = r_rx_byte;
        w_spi_clk_nxt  = r_spi_clk;
        w_spi_cs_nxt   = r_spi_cs;
        w_copi_nxt     = r_copi;

        case (r_state)
            ST_IDLE: begin
                w_spi_cs_nxt  = 1'b1;
                w_spi_clk_nxt = 1'b0;
                w_copi_nxt    = 1'b0;
                if (w_accept) begin
                    w_tx_sr_nxt  = tx_byte;
                    w_last_nxt   = tx_last;
                    w_spi_cs_nxt = 1'b0;
                    w_copi_nxt   = tx_byte[7];
                    w_div_nxt    = 8'd0;
                    w_bit_nxt    = 3'd7;
                    w_first_nxt  = 1'b0;
                    w_state_nxt  = ST_LEAD;
                end
            end
            ST_LEAD: begin
                if (w_div_end) begin
                    w_div_nxt     = 8'd0;
                    w_spi_clk_nxt = 1'b1;
                    w_rx_sr_nxt   = {r_rx_sr[6:0], spi_cipo};
                    w_state_nxt   = ST_SHIFT;
                end else begin
                    w_div_nxt = r_div + 8'd1;
                end
            end
            ST_SHIFT: begin
                if (!w_div_end) begin
                    w_div_nxt = r_div + 8'd1;
                end else begin
                    w_div_nxt = 8'd0;
                    if (r_spi_clk) begin
                        // End of high phase: fall, and present the next bit.
                        w_spi_clk_nxt = 1'b0;
                        if (r_bit != 3'd0) begin
                            w_tx_sr_nxt = {r_tx_sr[6:0], 1'b0};
                            w_copi_nxt  = r_tx_sr[6];
                        end
                    end else if (r_first) begin
                        w_first_nxt   = 1'b0;
                        w_spi_clk_nxt = 1'b1;
                        w_rx_sr_nxt   = {r_rx_sr[6:0], spi_cipo};
                    end else if (r_bit == 3'd0) begin
                        w_rx_valid_nxt = 1'b1;
                        w_rx_byte_nxt  = r_rx_sr;
                        w_state_nxt    = r_last ? ST_TRAIL : ST_WAIT;
                    end else begin
                        w_bit_nxt     = r_bit - 3'd1;
                        w_spi_clk_nxt = 1'b1;
                        w_rx_sr_nxt   = {r_rx_sr[6:0], spi_cipo};
                    end
                end
            end
            ST_TRAIL: begin
                if (w_div_end) begin
                    w_div_nxt    = 8'd0;
                    w_spi_cs_nxt = 1'b1;
                    w_copi_nxt   = 1'b0;
                    w_state_nxt  = ST_GAP;
                end else begin
                    w_div_nxt = r_div + 8'd1;
                end
            end
            ST_GAP: begin
                if (w_div_end) begin
                    w_div_nxt   = 8'd0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_div_nxt = r_div + 8'd1;
                end
            end
            ST_WAIT: begin
                w_spi_clk_nxt = 1'b0;
                if (w_accept) begin
                    w_tx_sr_nxt = tx_byte;
                    w_last_nxt  = tx_last;
                    w_copi_nxt  = tx_byte[7];
                    w_bit_nxt   = 3'd7;
                    w_div_nxt   = c_div_last;
                    w_first_nxt = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_tx_ready_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_WAIT);
        w_busy_nxt     = (w_state_nxt != ST_IDLE);
    end

    // State and output registers; reset returns everything to idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_div      <= 8'd0;
            r_bit      <= 3'd0;
            r_tx_sr    <= 8'd0;
            r_rx_sr    <= 8'd0;
            r_last     <= 1'b0;
            r_first    <= 1'b0;
            r_tx_ready <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_byte  <= 8'd0;
            r_busy     <= 1'b0;
            r_spi_clk  <= 1'b0;
            r_spi_cs   <= 1'b1;
            r_copi     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_div      <= w_div_nxt;
            r_bit      <= w_bit_nxt;
            r_tx_sr    <= w_tx_sr_nxt;
            r_rx_sr    <= w_rx_sr_nxt;
            r_last     <= w_last_nxt;
            r_first    <= w_first_nxt;
            r_tx_ready <= w_tx_ready_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_rx_byte  <= w_rx_byte_nxt;
            r_busy     <= w_busy_nxt;
            r_spi_clk  <= w_spi_clk_nxt;
            r_spi_cs   <= w_spi_cs_nxt;
            r_copi     <= w_copi_nxt;
        end
    end

    assign tx_ready = r_tx_ready;
    assign rx_valid = r_rx_valid;
    assign rx_byte  = r_rx_byte;
    assign busy     = r_busy;
    assign spi_clk  = r_spi_clk;
    assign spi_cs   = r_spi_cs;
    assign spi_copi = r_copi;

endmodule

`default_nettype wire

// File: tb/tb_spi_controller.sv
//==============================================================================
// Module      : tb_spi_controller
// Description : Self-checking bench for spi_controller. Two instances
//               (CLK_DIV=2 and CLK_DIV=1) share the stimulus; sel picks which
//               one is driven and observed. Expected rx bytes go to a queue.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_byte = 8'd0;
    logic       tx_last = 1'b0;
    logic       sel = 1'b0;   // 0: CLK_DIV=2 instance, 1: CLK_DIV=1 instance
    logic       loop = 1'b1;  // 1: spi_cipo tied to spi_copi, 0: target model

    always #5 clk = ~clk;

    logic       a_tx_ready, a_rx_valid, a_busy, a_spi_clk, a_spi_cs, a_spi_copi;
    logic [7:0] a_rx_byte;
    logic       b_tx_ready, b_rx_valid, b_busy, b_spi_clk, b_spi_cs, b_spi_copi;
    logic [7:0] b_rx_byte;

    logic       tx_ready, rx_valid, busy, spi_clk, spi_cs, spi_copi, spi_cipo;
    logic [7:0] rx_byte;
    logic [7:0] tgt_sr = 8'd0;
    logic [7:0] mosi_sr = 8'd0;

    assign tx_ready = sel ? b_tx_ready : a_tx_ready;
    assign rx_valid = sel ? b_rx_valid : a_rx_valid;
    assign rx_byte  = sel ? b_rx_byte  : a_rx_byte;
    assign busy     = sel ? b_busy     : a_busy;
    assign spi_clk  = sel ? b_spi_clk  : a_spi_clk;
    assign spi_cs   = sel ? b_spi_cs   : a_spi_cs;
    assign spi_copi = sel ? b_spi_copi : a_spi_copi;
    assign spi_cipo = loop ? spi_copi : tgt_sr[7];

    spi_controller #(.CLK_DIV(2)) dut_d2 (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid & ~sel),
        .tx_byte  (tx_byte),
        .tx_last  (tx_last),
        .tx_ready (a_tx_ready),
        .rx_valid (a_rx_valid),
        .rx_byte  (a_rx_byte),
        .busy     (a_busy),
        .spi_clk  (a_spi_clk),
        .spi_cs   (a_spi_cs),
        .spi_copi (a_spi_copi),
        .spi_cipo (spi_cipo)
    );

    spi_controller #(.CLK_DIV(1)) dut_d1 (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid & sel),
        .tx_byte  (tx_byte),
        .tx_last  (tx_last),
        .tx_ready (b_tx_ready),
        .rx_valid (b_rx_valid),
        .rx_byte  (b_rx_byte),
        .busy     (b_busy),
        .spi_clk  (b_spi_clk),
        .spi_cs   (b_spi_cs),
        .spi_copi (b_spi_copi),
        .spi_cipo (spi_cipo)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    int         rises, cs_low, cs_rises, rx_count, hi_hold;
    logic       prev_clk = 1'b0;
    logic       prev_cs  = 1'b1;
    logic       prev_copi = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Target model: presents its MSB before the first rise, shifts on each fall.
    always @(negedge spi_clk) tgt_sr <= {tgt_sr[6:0], 1'b0};

    // Bus monitor sampled away from the active edge.
    always @(negedge clk) begin
        if (spi_clk && !prev_clk) begin
            rises++;
            chk("copi_stable", spi_copi, prev_copi);
            mosi_sr = {mosi_sr[6:0], spi_copi};
        end
        if (spi_clk && prev_clk) hi_hold++;
        if (!spi_cs) cs_low++;
        if (spi_cs && !prev_cs) cs_rises++;
        if (rx_valid) begin
            rx_count++;
            if (exp_q.size() == 0) chk("rx_unexpected", 32'd1, 32'd0);
            else chk("rx_byte", rx_byte, exp_q.pop_front());
        end
        prev_clk  = spi_clk;
        prev_cs   = spi_cs;
        prev_copi = spi_copi;
    end

    task automatic clear_stats();
        rises = 0; cs_low = 0; cs_rises = 0; rx_count = 0; hi_hold = 0;
    endtask

    task automatic send(input logic [7:0] b, input logic last, input logic [7:0] exp_rx, input bit push);
        int n = 0;
        @(negedge clk);
        tx_byte = b; tx_last = last; tx_valid = 1'b1;
        while (!tx_ready && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) chk("send_timeout", 32'd0, 32'd1);
        if (push) exp_q.push_back(exp_rx);
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); n++; end while ((busy || !tx_ready) && n < 2000);
        if (n >= 2000) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n, gap, hold_bad;
        clear_stats();

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cs", spi_cs, 1);
        chk("rst_clk", spi_clk, 0);
        chk("rst_copi", spi_copi, 0);
        chk("rst_ready", tx_ready, 0);
        chk("rst_rxv", rx_valid, 0);
        chk("rst_rxb", rx_byte, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", tx_ready, 1);

        // Loopback single byte, CLK_DIV=2
        clear_stats(); loop = 1'b1;
        send(8'hA5, 1'b1, 8'hA5, 1'b1);
        n = 0;
        while (!spi_cs && n < 500) begin @(negedge clk); n++; end
        gap = 0;
        while (!tx_ready && gap < 100) begin @(negedge clk); gap++; end
        wait_idle();
        chk("t1_rises", rises, 8);
        chk("t1_cs_low", cs_low, 36);
        chk("t1_gap", gap, 2);
        chk("t1_rx_count", rx_count, 1);
        chk("t1_cs_rises", cs_rises, 1);

        // Target model returns 0x3C while 0xC3 is sent
        clear_stats(); loop = 1'b0; tgt_sr = 8'h3C; mosi_sr = 8'h00;
        send(8'hC3, 1'b1, 8'h3C, 1'b1);
        wait_idle();
        chk("t2_mosi", mosi_sr, 8'hC3);
        chk("t2_rises", rises, 8);
        chk("t2_rx_count", rx_count, 1);

        // Three-byte burst under one chip select
        clear_stats(); loop = 1'b1;
        send(8'h01, 1'b0, 8'h01, 1'b1);
        send(8'h02, 1'b0, 8'h02, 1'b1);
        send(8'h03, 1'b1, 8'h03, 1'b1);
        wait_idle();
        chk("t3_rises", rises, 24);
        chk("t3_cs_rises", cs_rises, 1);
        chk("t3_rx_count", rx_count, 3);

        // Burst with a 50-cycle stall in WAIT
        clear_stats();
        send(8'h5A, 1'b0, 8'h5A, 1'b1);
        n = 0;
        while (rx_count < 1 && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) chk("t4_rx_timeout", 32'd0, 32'd1);
        hold_bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!(spi_cs == 1'b0 && spi_clk == 1'b0 && tx_ready == 1'b1 && busy == 1'b1)) hold_bad++;
        end
        chk("t4_wait_hold", hold_bad, 0);
        send(8'h96, 1'b1, 8'h96, 1'b1);
        wait_idle();
        chk("t4_rx_count", rx_count, 2);
        chk("t4_cs_rises", cs_rises, 1);
        chk("t4_rises", rises, 16);

        // CLK_DIV=1 instance: 0xFF then 0x00
        sel = 1'b1;
        @(negedge clk);
        clear_stats();
        send(8'hFF, 1'b0, 8'hFF, 1'b1);
        send(8'h00, 1'b1, 8'h00, 1'b1);
        wait_idle();
        chk("t5_rises", rises, 16);
        chk("t5_hi_hold", hi_hold, 0);
        chk("t5_rx_count", rx_count, 2);
        sel = 1'b0;
        @(negedge clk);

        // Reset during the 4th bit, then a clean transfer
        clear_stats();
        send(8'h77, 1'b1, 8'h00, 1'b0);
        n = 0;
        while (rises < 4 && n < 500) begin @(negedge clk); n++; end
        #2 rst = 1'b1;
        #1;
        chk("t6_cs_async", spi_cs, 1);
        chk("t6_clk_async", spi_clk, 0);
        chk("t6_busy_async", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_no_rx", rx_count, 0);
        clear_stats();
        send(8'h5C, 1'b1, 8'h5C, 1'b1);
        wait_idle();
        chk("t6_rx_count", rx_count, 1);
        chk("t6_rises", rises, 8);
        chk("t6_cs_low", cs_low, 36);

        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
